// File: rtl/expression_decompose.sv
// Recovers a+b, c and d from a pair of adder-stage frames (one sel=1, one sel=0).
// Latency: out_valid rises on the edge that accepts the completing frame.
// Backpressure: in_ready drops while a completed pair waits (FULL); outputs hold until out_ready.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   sum1, sum2, sel, in_valid : incoming frame; in_ready accepts it
//   ab_out, c_out, d_out, err : recovered operands and consistency/range flag
//   out_valid, out_ready      : downstream handshake
//   pair_cnt                  : number of pairs delivered (wraps)
// Optional: define DECOMP_CHECK_EN to enable the consistency/range check on err;
//   otherwise err is tied to 0.
module expression_decompose #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W:0]       sum1,
  input  logic [W:0]       sum2,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W:0]       ab_out,
  output logic [W-1:0]     c_out,
  output logic [W-1:0]     d_out,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {EMPTY, HAVE_P, HAVE_Q, FULL} state_t;

  state_t     state, state_n;
  logic [W:0] ab_r, c_r, d_r, q2_r;
  logic [W:0] ab_n, c_n, d_n, q2_n;
  logic       accept;

  assign accept = in_valid & in_ready;

  // Register values as they will be after this edge's capture (if any).
  // A sel=1 frame carries a+b and a+b+c; a sel=0 frame carries a+b+c+d and a+b+c.
  always_comb begin
    ab_n = ab_r;
    c_n  = c_r;
    d_n  = d_r;
    q2_n = q2_r;
    if (accept) begin
      if (sel) begin
        ab_n = sum1;
        c_n  = sum2 - sum1;
      end else begin
        d_n  = sum1 - sum2;
        q2_n = sum2;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (accept) state_n = sel ? HAVE_P : HAVE_Q;
      HAVE_P:  if (accept && !sel) state_n = FULL;
      HAVE_Q:  if (accept &&  sel) state_n = FULL;
      FULL:    if (out_ready) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

`ifdef DECOMP_CHECK_EN
  logic [W:0] abc_sum;
  logic       err_n;

  // The two frames must agree on a+b+c, and c/d must fit in W bits.
  assign abc_sum = ab_n + c_n;
  assign err_n   = (abc_sum != q2_n) | c_n[W] | d_n[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state != FULL && state_n == FULL) begin
      err <= err_n;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{c_r[W], d_r[W], q2_r};
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      pair_cnt  <= '0;
      ab_r      <= '0;
      c_r       <= '0;
      d_r       <= '0;
      q2_r      <= '0;
    end else begin
      state     <= state_n;
      // Decoded one edge ahead so in_ready is a clean register output.
      in_ready  <= (state_n != FULL);
      out_valid <= (state_n == FULL);
      ab_r      <= ab_n;
      c_r       <= c_n;
      d_r       <= d_n;
      q2_r      <= q2_n;
      if (state == FULL && out_ready) begin
        pair_cnt <= pair_cnt + CNT_W'(1);
      end
    end
  end

  assign ab_out = ab_r;
  assign c_out  = c_r[W-1:0];
  assign d_out  = d_r[W-1:0];

endmodule

// File: tb/tb_expression_decompose.sv
module tb_expression_decompose;

  localparam int W     = 4;
  localparam int CNT_W = 8;

`ifdef DECOMP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [W:0]   ab;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic         err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W:0]       sum1, sum2;
  logic             sel, in_valid, in_ready;
  logic [W:0]       ab_out;
  logic [W-1:0]     c_out, d_out;
  logic             err, out_valid, out_ready;
  logic [CNT_W-1:0] pair_cnt;

  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;
  exp_t exp_q[$];

  expression_decompose #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .sum1(sum1), .sum2(sum2), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .ab_out(ab_out), .c_out(c_out), .d_out(d_out), .err(err),
    .out_valid(out_valid), .out_ready(out_ready),
    .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one frame and hold it until accepted (bounded).
  task automatic send(input logic [W:0] s1, input logic [W:0] s2, input logic sl);
    int n = 0;
    @(negedge clk);
    sum1 = s1; sum2 = s2; sel = sl; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push(input logic [W:0] ab, input logic [W-1:0] c, input logic [W-1:0] d,
                      input logic e);
    exp_t x;
    x.ab = ab; x.c = c; x.d = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Called just after the completing frame's accept edge: out_valid must already be up.
  task automatic take(input string tag, input int hold);
    exp_t x;
    chk({tag, "_out_valid"}, out_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_nonempty"}, exp_q.size(), 1);
      return;
    end
    x = exp_q.pop_front();
    chk({tag, "_ab"},  ab_out, x.ab);
    chk({tag, "_c"},   c_out,  x.c);
    chk({tag, "_d"},   d_out,  x.d);
    chk({tag, "_err"}, err,    x.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_in_ready"},  in_ready,  0);
      chk({tag, "_hold_out_valid"}, out_valid, 1);
      chk({tag, "_hold_ab"},        ab_out,    x.ab);
      chk({tag, "_hold_c"},         c_out,     x.c);
      chk({tag, "_hold_d"},         d_out,     x.d);
      chk({tag, "_hold_err"},       err,       x.err);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk({tag, "_pair_cnt"},       pair_cnt,  exp_cnt);
    chk({tag, "_out_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"},  in_ready,  1);
  endtask

  initial begin
    rst_n = 1'b0; sum1 = '0; sum2 = '0; sel = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pair_cnt",  pair_cnt,  0);
    chk("rst_ab",        ab_out,    0);
    chk("rst_c",         c_out,     0);
    chk("rst_d",         d_out,     0);
    chk("rst_err",       err,       0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", in_ready, 1);

    // a=3 b=5 c=7 d=9.
    send(5'd8, 5'd15, 1'b1);
    chk("basic_no_early_valid", out_valid, 0);
    push(5'd8, 4'd7, 4'd9, 1'b0);
    send(5'd24, 5'd15, 1'b0);
    take("basic", 0);

    // All operands 15, sel=0 frame first; a+b+c+d wraps to 28.
    send(5'd28, 5'd13, 1'b0);
    push(5'd30, 4'd15, 4'd15, 1'b0);
    send(5'd30, 5'd13, 1'b1);
    take("wrap", 0);

    // Frames disagree on a+b+c.
    send(5'd8, 5'd15, 1'b1);
    push(5'd8, 4'd7, 4'd10, CHK);
    send(5'd24, 5'd14, 1'b0);
    take("mismatch", 0);

    // c difference 20 exceeds W bits.
    send(5'd5, 5'd25, 1'b1);
    push(5'd5, 4'd4, 4'd0, CHK);
    send(5'd25, 5'd25, 1'b0);
    take("range", 0);

    // Overwrite of held sel=1 frame, then backpressure for 5 cycles.
    send(5'd8, 5'd15, 1'b1);
    send(5'd2, 5'd6, 1'b1);
    push(5'd2, 4'd4, 4'd4, 1'b0);
    send(5'd10, 5'd6, 1'b0);
    take("overwrite_bp", 5);

    // Reset while holding a sel=1 frame.
    send(5'd8, 5'd15, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  in_ready,  0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pair_cnt",  pair_cnt,  0);
    chk("midrst_ab",        ab_out,    0);
    chk("midrst_c",         c_out,     0);
    chk("midrst_d",         d_out,     0);
    chk("midrst_err",       err,       0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    send(5'd24, 5'd15, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_lone_q_no_valid", out_valid, 0);
    end
    chk("midrst_lone_q_in_ready", in_ready, 1);
    chk("midrst_lone_q_pair_cnt", pair_cnt, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expression_decompose.md
Name: expression_decompose

Overview:
- Consumer end of the registered adder-expression stage that emits data_out1/data_out2 under sel.
- Takes frames of (sum1, sum2, sel) over a valid/ready handshake.
  - sel=1 frame: sum1=a+b, sum2=a+b+c.
  - sel=0 frame: sum1=a+b+c+d, sum2=a+b+c.
- Pairs one frame of each kind and recovers a+b, c and d, then presents them downstream with a valid/ready handshake.
- Sits directly behind the adder stage, for self-checking and debug readback.

Parameters:
- W, 4, operand width; sums are W+1 bits, and all arithmetic is modulo 2^(W+1).
- CNT_W, 8, width of the decoded-pair counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sum1  input  W+1  data_out1 of the frame.
- sum2  input  W+1  data_out2 of the frame.
- sel  input  1  sel value that produced the frame.
- in_valid  input  1  frame present.
- in_ready  output  1  frame accepted when in_valid & in_ready.
- ab_out  output  W+1  recovered a+b.
- c_out  output  W  recovered c.
- d_out  output  W  recovered d.
- err  output  1  consistency or range error for this pair.
- out_valid  output  1  recovered set valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- pair_cnt  output  CNT_W  count of pairs delivered (handshakes completed); wraps to 0.

Behaviour:
- Reset is one clock with asynchronous active-low reset rst_n.
- Reset values (async):
  - state=EMPTY.
  - out_valid=0; ab_out, c_out, d_out = 0; err=0; pair_cnt=0.
  - in_ready=0 while rst_n is low; in_ready is decoded from state, so it is 1 from the first edge after release.
- States: EMPTY, HAVE_P (sel=1 frame held), HAVE_Q (sel=0 frame held), FULL.
- in_ready = 1 in EMPTY, HAVE_P and HAVE_Q; 0 in FULL. There is no bypass.
- Capturing a sel=1 frame:
  - ab_r = sum1.
  - c_r = sum2 - sum1 (mod 2^(W+1)); c_out takes the low W bits.
  - Also keep the full (W+1)-bit difference for the range check.
- Capturing a sel=0 frame:
  - d_r = sum1 - sum2 (mod 2^(W+1)); d_out takes the low W bits.
  - q2_r = sum2.
- Transitions:
  - EMPTY + accept sel=1 → HAVE_P.
  - EMPTY + accept sel=0 → HAVE_Q.
  - HAVE_P + sel=1 → newer frame overwrites the held one; stay in HAVE_P.
  - HAVE_P + sel=0 → FULL.
  - HAVE_Q + sel=0 → overwrite; stay in HAVE_Q.
  - HAVE_Q + sel=1 → FULL.
  - FULL + out_ready → EMPTY, and pair_cnt increments on that edge.
- Latency: out_valid rises on the clock edge that accepts the completing frame, i.e. it is visible the cycle after the accept.
- ab_out, c_out, d_out and err are stable while out_valid=1 and out_ready=0.
- Output fields do not change outside FULL except through capture. Fields are undefined-but-deterministic (last captured) when out_valid=0.
- Wrap-around:
  - Sums wrap mod 2^(W+1); subtraction is mod 2^(W+1).
  - Operands below 2^W are therefore recovered exactly even when a+b+c+d overflows.
- Reset mid-operation (any state): any partially held pair is discarded, all outputs return to their reset values, and no output handshake occurs.
- An out_ready pulse while out_valid=0 is ignored.

Optional Feature:
- Macro: DECOMP_CHECK_EN.
- Defined: err is registered on entry to FULL and is 1 if any of the following holds:
  - (ab_r + c_r) mod 2^(W+1) != q2_r, i.e. the two frames disagree on a+b+c.
  - The full c difference is ≥ 2^W.
  - The full d difference is ≥ 2^W.
  - Otherwise err = 0.
- Not defined: err is tied 0 and the check logic is absent. The port remains, and all other behaviour is identical.

Test Plan:
- a=3,b=5,c=7,d=9: frame sel=1 (sum1=8, sum2=15), then frame sel=0 (sum1=24, sum2=15) → next cycle out_valid=1, ab_out=8, c_out=7, d_out=9, err=0; after out_ready, pair_cnt=1.
- All operands 15: sel=0 (28, 13) first, then sel=1 (30, 13) → ab_out=30, c_out=15, d_out=15, err=0, despite the wrap to 28.
- Mismatch with macro defined: sel=1 (8, 15), then sel=0 (24, 14) → d_out=10, err=1. With the macro undefined, err=0.
- Range with macro defined: sel=1 (5, 25) → c difference = 20 ≥ 16, so err=1 when the pair completes with sel=0 (25, 25).
- Backpressure and overwrite:
  - Two sel=1 frames, (8, 15) then (2, 6), then sel=0 (10, 6) → ab_out=2, c_out=4, d_out=4.
  - Hold out_ready=0 for 5 cycles → in_ready=0 and outputs stable throughout.
- Reset mid-operation: pull rst_n low in HAVE_P → all outputs 0, state EMPTY.
  - A following sel=0 frame alone produces no out_valid.
